// File: rtl/instr_stream_shaper_if.sv
// Handshake bundle between the instruction source/pipeline and the stream shaper.
// The shaper takes the slave side; the source and pipeline take the master side.
interface instr_stream_shaper_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 stall;
    logic                 flush;
    logic [31:0]          raw_instr_i;
    logic [31:0]          instruction_o;
    logic                 bubble_o;
    logic                 illegal_o;
    logic [CNT_WIDTH-1:0] illegal_cnt_o;

    modport master (
        output stall, flush, raw_instr_i,
        input  instruction_o, bubble_o, illegal_o, illegal_cnt_o
    );

    modport slave (
        input  stall, flush, raw_instr_i,
        output instruction_o, bubble_o, illegal_o, illegal_cnt_o
    );
endinterface

// File: rtl/instr_stream_shaper.sv
// Registers a raw instruction word into a pipeline-legal stream: holds output on stall,
// emits FLUSH_DEPTH zero bubbles after a flush, and legalises or flags illegal opcodes.
module instr_stream_shaper #(
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter bit          ENABLE_M    = 1'b1,
    parameter bit          ENABLE_A    = 1'b1,
    parameter bit          ALLOW_ZERO  = 1'b1,
    parameter bit          LEGALIZE    = 1'b1,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input logic                  clk,
    input logic                  reset,
    instr_stream_shaper_if.slave bus
);
    typedef enum logic {RUN, FLUSH} state_e;

    localparam logic [31:0]          NOP     = 32'h0000_0013;
    localparam logic [3:0]           CNT_RLD = 4'(FLUSH_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] ILL_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] ILL_MAX = '1;

    state_e               state_q, state_d;
    logic [3:0]           fcnt_q, fcnt_d;
    logic [31:0]          instr_q, instr_d;
    logic                 bubble_q, bubble_d;
    logic                 illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0] icnt_q, icnt_d;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       legal;

    assign opcode = bus.raw_instr_i[6:0];
    assign funct7 = bus.raw_instr_i[31:25];

    always_comb begin
        legal = 1'b0;
        if (bus.raw_instr_i == 32'h0) begin
            legal = ALLOW_ZERO;
        end else begin
            unique case (opcode)
                7'b0000011, 7'b1100011, 7'b0010011, 7'b0010111, 7'b1100111,
                7'b1101111, 7'b0100011, 7'b0110111: legal = 1'b1;
                7'b0101111: legal = ENABLE_A;
                7'b0110011: legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000) ||
                                    (ENABLE_M && (funct7 == 7'b0000001));
                default:    legal = 1'b0;
            endcase
        end
    end

    // Priority: flush, then stall (freeze everything), then bubble countdown, then load.
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        instr_d   = instr_q;
        bubble_d  = bubble_q;
        illegal_d = illegal_q;
        icnt_d    = icnt_q;
        if (bus.flush) begin
            state_d   = FLUSH;
            fcnt_d    = CNT_RLD;
            instr_d   = 32'h0;
            bubble_d  = 1'b1;
            illegal_d = 1'b0;
        end else if (!bus.stall) begin
            // stall is active-low: hold all state
        end else if (state_q == FLUSH && fcnt_q != 4'd0) begin
            fcnt_d = fcnt_q - 4'd1;
        end else begin
            state_d   = RUN;
            bubble_d  = 1'b0;
            illegal_d = !legal;
            instr_d   = (!legal && LEGALIZE) ? NOP : bus.raw_instr_i;
            if (!legal && icnt_q != ILL_MAX) icnt_d = icnt_q + ILL_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            fcnt_q    <= 4'd0;
            instr_q   <= 32'h0;
            bubble_q  <= 1'b0;
            illegal_q <= 1'b0;
            icnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            instr_q   <= instr_d;
            bubble_q  <= bubble_d;
            illegal_q <= illegal_d;
            icnt_q    <= icnt_d;
        end
    end

    assign bus.instruction_o = instr_q;
    assign bus.bubble_o      = bubble_q;
    assign bus.illegal_o     = illegal_q;
    assign bus.illegal_cnt_o = icnt_q;
endmodule

// File: doc/instr_stream_shaper.md
Name: instr_stream_shaper

Overview:
Parametrised RTL instruction-stream shaper feeding the RV32IMA pipeline under formal and simulation benches. Takes a free-running raw instruction word and produces a pipeline-legal stream. Holds its output while stalled, inserts a configurable number of zero bubbles after a flush, and legalises or flags opcodes and funct7 outside the enabled ISA subset. Tracks illegal-instruction statistics in a saturating counter.

Parameters:
FLUSH_DEPTH, 1, number of zero words emitted after a flush (1..15)
ENABLE_M, 1, 1 = accept funct7 0000001 on opcode 0110011 (M extension)
ENABLE_A, 1, 1 = accept opcode 0101111 (A extension)
ALLOW_ZERO, 1, 1 = all-zero word is a legal input
LEGALIZE, 1, 1 = replace illegal words with 32'h00000013; 0 = pass through and flag only
CNT_WIDTH, 8, width of illegal_cnt_o

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  active-low: 0 = pipeline stalled, hold output
flush  in  1  active-high pipeline flush request
raw_instr_i  in  32  unconstrained candidate instruction
instruction_o  out  32  registered instruction to pipeline
bubble_o  out  1  1 while instruction_o is a flush bubble
illegal_o  out  1  1 when the word loaded into instruction_o was illegal
illegal_cnt_o  out  CNT_WIDTH  saturating count of illegal words loaded

Behaviour:
- Reset (reset=0, asynchronous): instruction_o=0, bubble_o=0, illegal_o=0, illegal_cnt_o=0, state=RUN, flush counter=0.
- Latency: one cycle. instruction_o reflects raw_instr_i sampled on the previous edge when in RUN with stall=1.
- Legal set: opcodes 0000011, 1100011, 0110011, 0010011, 0010111, 1100111, 1101111, 0100011, 0110111. Adds 0101111 iff ENABLE_A, and the all-zero word iff ALLOW_ZERO.
- Opcode 0110011 is legal only with funct7 in {0000000, 0100000}, plus 0000001 iff ENABLE_M.
- States: RUN, FLUSH.
- Per-edge priority: flush > stall > load.
- flush=1, any state: next instruction_o=0, bubble_o=1, illegal_o=0, state=FLUSH, counter=FLUSH_DEPTH-1. A flush during FLUSH reloads the counter.
- FLUSH, flush=0, stall=0: all outputs frozen, counter frozen.
- FLUSH, flush=0, stall=1, counter>0: output stays 0, counter decrements.
- FLUSH, flush=0, stall=1, counter=0: load a raw sample exactly as in RUN, state=RUN. Total bubbles = FLUSH_DEPTH cycles of stall=1.
- RUN, stall=0, no flush: instruction_o, bubble_o and illegal_o hold their values. No counting.
- RUN, stall=1, no flush (load): bubble_o=0, illegal_o=legality of the raw sample.
  - Legal sample: instruction_o=raw.
  - Illegal sample: instruction_o=32'h00000013 if LEGALIZE, else raw.
  - illegal_cnt_o increments by 1 on each illegal load and saturates at all-ones, with no wrap.
- Output invariants with LEGALIZE=1: every non-bubble instruction_o is in the legal set; instruction_o is stable across any stall=0 cycle; it is 0 on the cycle after any flush.
- Reset asserted mid-FLUSH or mid-stall: immediate return to reset values. The first load after release occurs on the first edge with stall=1 and flush=0.

Test Plan:
- Reset release, stall=1, raw=32'h00A00093 -> instruction_o=32'h00A00093 one cycle later, illegal_o=0, illegal_cnt_o=0.
- Load 32'h00500513, then stall=0 for 3 cycles with raw changing every cycle -> instruction_o=32'h00500513 throughout.
- FLUSH_DEPTH=3, flush pulse with stall=1 -> instruction_o=0 and bubble_o=1 for exactly 3 cycles, then next raw loaded. A stall=0 cycle inside the window extends it to 4 cycles.
- LEGALIZE=1, raw opcode 1111111 -> instruction_o=32'h00000013, illegal_o=1, illegal_cnt_o=1. With LEGALIZE=0 -> raw passes through, same flag and count.
- ENABLE_M=0, raw=32'h02B50533 (MUL) -> illegal. ENABLE_M=1 -> passes unchanged. ENABLE_A=0, raw=32'h0805A2AF -> illegal.
- CNT_WIDTH=2, 5 illegal loads -> illegal_cnt_o=3 and holds. Flush and stall in the same cycle -> flush wins, bubble emitted. Reset mid-FLUSH -> all outputs 0 immediately.
